// File: rtl/unpack_queue_if.sv
// unpack_queue_if: wide-in / narrow-out stream bundle for the unpacker.
interface unpack_queue_if #(parameter int IN_WIDTH = 64, parameter int OUT_WIDTH = 32);
   logic [IN_WIDTH-1:0]  din;
   logic                 vld_in;
   logic                 rdy_upward;
   logic [OUT_WIDTH-1:0] dout;
   logic                 vld_out;
   logic                 rdy_downward;
   modport master (output din, vld_in, rdy_downward, input rdy_upward, dout, vld_out);
   modport slave  (input din, vld_in, rdy_downward, output rdy_upward, dout, vld_out);
endinterface

// File: rtl/unpack_queue.sv
// unpack_queue: splits each wide word into IN_WIDTH/OUT_WIDTH narrow slices, LS slice first.
module unpack_queue #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   unpack_queue_if.slave q
);
   localparam int MAX = IN_WIDTH / OUT_WIDTH;
   localparam int CW  = $clog2(MAX) + 1;
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] dbuf_q, dbuf_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                last, in_fire, out_fire;
   assign last         = cnt_q == CW'(MAX - 1);
   assign q.vld_out    = state_q == DRAIN;
   assign q.dout       = q.vld_out ? dbuf_q[OUT_WIDTH-1:0] : '0;
   // reload on the last slice's handshake keeps the output stream bubble-free
   assign q.rdy_upward = !reset && (state_q == IDLE || (last && q.rdy_downward));
   assign in_fire      = q.vld_in && q.rdy_upward;
   assign out_fire     = q.vld_out && q.rdy_downward;
   always_comb begin
      state_d = state_q;
      dbuf_d  = dbuf_q;
      cnt_d   = cnt_q;
      if (in_fire) begin
         dbuf_d  = q.din;
         cnt_d   = '0;
         state_d = DRAIN;
      end else if (out_fire && !last) begin
         dbuf_d = dbuf_q >> OUT_WIDTH;
         cnt_d  = cnt_q + CW'(1);
      end else if (out_fire) begin
         cnt_d   = '0;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dbuf_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dbuf_q  <= dbuf_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
